// File: rtl/b01_serial_flow_comparator.sv
// Compares two serial bit flows with an 8-state FSM and emits a serial result bit plus an overflow pulse.
// Latency: one clock from sampled inputs to registered outp/overflw.
// No backpressure: both line inputs are sampled on every rising edge.
module b01_serial_flow_comparator (
  input  logic clock,
  input  logic reset,
  input  logic line1,
  input  logic line2,
  output logic outp,
  output logic overflw
);

  typedef enum logic [2:0] {
    ST_A   = 3'd0,
    ST_B   = 3'd1,
    ST_C   = 3'd2,
    ST_E   = 3'd3,
    ST_F   = 3'd4,
    ST_G   = 3'd5,
    ST_WF0 = 3'd6,
    ST_WF1 = 3'd7
  } state_t;

  state_t state;
  state_t next_state;
  logic   next_outp;
  logic   next_overflw;

  logic flow_xor;
  logic flow_and;
  logic flow_or;

  assign flow_xor = line1 ^ line2;
  assign flow_and = line1 & line2;
  assign flow_or  = line1 | line2;

  // State and both outputs update together; reset clears them immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_A;
      outp    <= 1'b0;
      overflw <= 1'b0;
    end else begin
      state   <= next_state;
      outp    <= next_outp;
      overflw <= next_overflw;
    end
  end

  // Next state and next registered outputs from current state and sampled flows.
  // A/E and their successors share the same next-state rule but differ in which
  // input condition (and vs. or) selects the carry branch; E alone raises overflw.
  always_comb begin
    next_state   = ST_A;
    next_outp    = 1'b0;
    next_overflw = 1'b0;
    case (state)
      ST_A: begin
        next_state = flow_and ? ST_F : ST_B;
        next_outp  = flow_xor;
      end
      ST_E: begin
        next_state   = flow_and ? ST_F : ST_B;
        next_outp    = flow_xor;
        next_overflw = 1'b1;
      end
      ST_B: begin
        next_state = flow_and ? ST_G : ST_C;
        next_outp  = ~flow_xor;
      end
      ST_F: begin
        next_state = flow_or ? ST_G : ST_C;
        next_outp  = ~flow_xor;
      end
      ST_C: begin
        next_state = flow_and ? ST_WF1 : ST_WF0;
        next_outp  = flow_xor;
      end
      ST_G: begin
        next_state = flow_or ? ST_WF1 : ST_WF0;
        next_outp  = flow_xor;
      end
      ST_WF0: begin
        next_state = flow_and ? ST_E : ST_A;
        next_outp  = ~flow_xor;
      end
      ST_WF1: begin
        next_state = flow_or ? ST_E : ST_A;
        next_outp  = ~flow_xor;
      end
      default: begin
        // Any corrupted code falls back to A with quiet outputs.
        next_state   = ST_A;
        next_outp    = 1'b0;
        next_overflw = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_b01_serial_flow_comparator.sv
module tb_b01_serial_flow_comparator;

  logic clock;
  logic reset;
  logic line1;
  logic line2;
  logic outp;
  logic overflw;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic o;
    logic v;
  } exp_t;

  exp_t sb[$];

  localparam int SA = 0, SB = 1, SC = 2, SE = 3, SF = 4, SG = 5, SW0 = 6, SW1 = 7;
  int ms;

  b01_serial_flow_comparator dut (
    .clock   (clock),
    .reset   (reset),
    .line1   (line1),
    .line2   (line2),
    .outp    (outp),
    .overflw (overflw)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed outp,overflw=%b required=%b", tag, obs, exp);
    end
  endtask

  // Drive one input pair, push the expected result, then compare once the DUT has clocked it.
  task automatic step(input logic l1, input logic l2, input logic eo, input logic ev, input string tag);
    exp_t e;
    @(negedge clock);
    line1 = l1;
    line2 = l2;
    sb.push_back('{o: eo, v: ev});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk(tag, {outp, overflw}, {e.o, e.v});
  endtask

  // Pulse reset across one rising edge and release before the next falling edge.
  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk(tag, {outp, overflw}, 2'b00);
    #2;
    reset = 1'b1;
  endtask

  // Reference behaviour: returns the outputs the DUT should register and advances ms.
  task automatic model_step(input logic l1, input logic l2, output logic eo, output logic ev);
    logic x, a, o;
    x  = l1 ^ l2;
    a  = l1 & l2;
    o  = l1 | l2;
    ev = 1'b0;
    eo = 1'b0;
    case (ms)
      SA:  begin eo = x;  ms = a ? SF : SB; end
      SE:  begin eo = x;  ev = 1'b1; ms = a ? SF : SB; end
      SB:  begin eo = ~x; ms = a ? SG : SC; end
      SF:  begin eo = ~x; ms = o ? SG : SC; end
      SC:  begin eo = x;  ms = a ? SW1 : SW0; end
      SG:  begin eo = x;  ms = o ? SW1 : SW0; end
      SW0: begin eo = ~x; ms = a ? SE : SA; end
      default: begin eo = ~x; ms = o ? SE : SA; end
    endcase
  endtask

  initial begin
    logic eo, ev, l1, l2;
    reset = 1'b0;
    line1 = 1'b0;
    line2 = 1'b0;

    // Reset held low with random inputs and a running clock.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      line1 = 1'($urandom_range(0, 1));
      line2 = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      chk("reset_hold", {outp, overflw}, 2'b00);
    end
    #2;
    reset = 1'b1;

    // All-zero flow: A->B->C->WF0->A, twice.
    for (int r = 0; r < 2; r++) begin
      step(0, 0, 0, 0, "zero_A_B");
      step(0, 0, 1, 0, "zero_B_C");
      step(0, 0, 0, 0, "zero_C_WF0");
      step(0, 0, 1, 0, "zero_WF0_A");
    end

    // Carry path: F, C, WF1, A.
    do_reset("reset_carry");
    step(1, 1, 0, 0, "carry_A_F");
    step(0, 0, 1, 0, "carry_F_C");
    step(1, 1, 0, 0, "carry_C_WF1");
    step(0, 0, 1, 0, "carry_WF1_A");

    // Overflow: F, G, WF1, E, B, then B->C.
    do_reset("reset_ovf");
    step(1, 1, 0, 0, "ovf_A_F");
    step(1, 0, 0, 0, "ovf_F_G");
    step(1, 0, 1, 0, "ovf_G_WF1");
    step(1, 0, 0, 0, "ovf_WF1_E");
    step(0, 1, 1, 1, "ovf_E_B");
    step(0, 0, 1, 0, "ovf_B_C");

    // Asynchronous reset between edges while sitting in WF1 (outp=1).
    do_reset("reset_async1");
    step(1, 1, 0, 0, "async_A_F");
    step(1, 0, 0, 0, "async_F_G");
    step(1, 0, 1, 0, "async_G_WF1");
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_wf1", {outp, overflw}, 2'b00);
    reset = 1'b1;
    step(1, 1, 0, 0, "async_rel_A_F");
    step(1, 1, 1, 0, "async_rel_F_G");

    // Asynchronous reset while overflw is high.
    do_reset("reset_async2");
    step(1, 1, 0, 0, "async2_A_F");
    step(1, 0, 0, 0, "async2_F_G");
    step(1, 0, 1, 0, "async2_G_WF1");
    step(1, 0, 0, 0, "async2_WF1_E");
    step(0, 1, 1, 1, "async2_E_B");
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_ovf", {outp, overflw}, 2'b00);
    reset = 1'b1;
    step(0, 0, 0, 0, "async2_rel_A_B");

    // Back-to-back overflow pulses with (1,1) held.
    do_reset("reset_b2b");
    step(1, 1, 0, 0, "b2b_A_F");
    step(1, 1, 1, 0, "b2b_F_G");
    step(1, 1, 0, 0, "b2b_G_WF1");
    step(1, 1, 1, 0, "b2b_WF1_E");
    step(1, 1, 0, 1, "b2b_E_F");
    step(1, 1, 1, 0, "b2b_F_G2");
    step(1, 1, 0, 0, "b2b_G_WF1_2");
    step(1, 1, 1, 0, "b2b_WF1_E2");
    step(1, 1, 0, 1, "b2b_E_F2");
    step(0, 0, 1, 0, "b2b_F_C");

    // Random flows against the reference behaviour.
    do_reset("reset_rand");
    ms = SA;
    for (int i = 0; i < 400; i++) begin
      l1 = 1'($urandom_range(0, 1));
      l2 = 1'($urandom_range(0, 1));
      model_step(l1, l2, eo, ev);
      step(l1, l2, eo, ev, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
